// File: rtl/mem_arbiter.sv
// Arbitrates one instruction port and one data port onto a single RAM port.
// Data wins unless an instruction waits right after a data completion; per-access timeout latches ERR.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        timeout_err
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, IACC, DACC, ERR} state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dreq;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dreq && !(iREN && last_d_q)) state_d = DACC;
        else if (iREN)                   state_d = IACC;
      end
      IACC: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramready) begin
            iwait    = 1'b0;
            last_d_d = 1'b0;
            state_d  = IDLE;
          end else if (cnt_q == TMO) begin
            state_d = ERR;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ramready) begin
          dwait    = 1'b0;
          last_d_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == TMO) begin
          state_d = ERR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        timeout_err = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Reset masks the handshake outputs so an in-flight completion cannot leak out.
    if (RST) begin
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      iwait       = 1'b1;
      dwait       = 1'b1;
      timeout_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus a timeout/error sequence.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST, iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        rst, iren;
    logic [31:0] iaddr;
    logic        dren, dwen;
    logic [31:0] daddr, dstore, rload;
    logic        rrdy;
    logic        e_ren, e_wen, e_iw, e_dw, e_err;
    int          chk;   // 0: handshake only, 1: +instr path, 2: +data path
    logic [31:0] e_addr, e_store, e_load;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rst, iren, input logic [31:0] ia, input logic dren, dwen,
    input logic [31:0] da, ds, rl, input logic rr,
    input logic ren, wen, iw, dw, er, input int ck,
    input logic [31:0] ea, es, el);
    vec_t v;
    v.rst = rst; v.iren = iren; v.iaddr = ia; v.dren = dren; v.dwen = dwen;
    v.daddr = da; v.dstore = ds; v.rload = rl; v.rrdy = rr;
    v.e_ren = ren; v.e_wen = wen; v.e_iw = iw; v.e_dw = dw; v.e_err = er;
    v.chk = ck; v.e_addr = ea; v.e_store = es; v.e_load = el;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, iren, input logic [31:0] ia,
                       input logic dren, dwen, input logic [31:0] da, ds, rl,
                       input logic rr);
    RST = rst; iREN = iren; iaddr = ia; dREN = dren; dWEN = dwen;
    daddr = da; dstore = ds; ramload = rl; ramready = rr;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset
    vq.push_back(mk(1,0,32'h0,0,0,32'h0,32'h0,32'h0,0,          0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(1,1,32'h0,0,0,32'h0,32'h0,32'h0,1,          0,0,1,1,0, 0,0,0,0));
    // single instruction read, completes in 2nd cycle
    vq.push_back(mk(0,1,32'h40,0,0,32'h0,32'h0,32'h0,0,         0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,1,32'h40,0,0,32'h0,32'h0,32'h20020005,1,  1,0,0,1,0, 1,32'h40,0,32'h20020005));
    vq.push_back(mk(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0,          0,0,1,1,0, 0,0,0,0));
    // instr + data write together: data first, then instr even with dWEN still held
    vq.push_back(mk(0,1,32'h44,0,1,32'h100,32'hDEADBEEF,32'h0,0,        0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,1,32'h44,0,1,32'h100,32'hDEADBEEF,32'h11111111,1, 0,1,1,0,0, 2,32'h100,32'hDEADBEEF,32'h11111111));
    vq.push_back(mk(0,1,32'h44,0,1,32'h100,32'hDEADBEEF,32'h0,0,        0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,1,32'h44,0,1,32'h100,32'hDEADBEEF,32'h22222222,1, 1,0,0,1,0, 1,32'h44,0,32'h22222222));
    vq.push_back(mk(0,0,32'h0,0,1,32'h100,32'hDEADBEEF,32'h0,0,         0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,0,32'h0,0,1,32'h100,32'hDEADBEEF,32'h0,1,         0,1,1,0,0, 2,32'h100,32'hDEADBEEF,32'h0));
    // dREN and dWEN together: write wins
    vq.push_back(mk(0,0,32'h0,1,1,32'h104,32'hCAFEF00D,32'h0,0,         0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,0,32'h0,1,1,32'h104,32'hCAFEF00D,32'h0,0,         0,1,1,1,0, 2,32'h104,32'hCAFEF00D,32'h0));
    vq.push_back(mk(0,0,32'h0,1,1,32'h104,32'hCAFEF00D,32'h0,1,         0,1,1,0,0, 2,32'h104,32'hCAFEF00D,32'h0));
    // data read aborted after 3 stalled cycles
    vq.push_back(mk(0,0,32'h0,1,0,32'h200,32'h0,32'h33333333,0,         0,0,1,1,0, 0,0,0,0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0,0,32'h0,1,0,32'h200,32'h0,32'h33333333,0,       1,0,1,1,0, 2,32'h200,32'h0,32'h33333333));
    vq.push_back(mk(0,0,32'h0,0,0,32'h200,32'h0,32'h0,0,                0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0,                  0,0,1,1,0, 0,0,0,0));
    // last_d survived the abort, so the instruction is granted first
    vq.push_back(mk(0,1,32'h80,1,0,32'h200,32'h0,32'h0,0,               0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,1,32'h80,1,0,32'h200,32'h0,32'h44444444,0,        1,0,1,1,0, 1,32'h80,0,32'h44444444));
    // reset on the completing IACC cycle: no iwait pulse, last_d cleared -> data next
    vq.push_back(mk(1,1,32'h80,1,0,32'h200,32'h0,32'h0,1,               0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,1,32'h80,1,0,32'h200,32'h0,32'h0,0,               0,0,1,1,0, 0,0,0,0));
    vq.push_back(mk(0,1,32'h80,1,0,32'h200,32'h0,32'h55555555,1,        1,0,1,0,0, 2,32'h200,32'h0,32'h55555555));
    vq.push_back(mk(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0,                  0,0,1,1,0, 0,0,0,0));

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].iren, vq[k].iaddr, vq[k].dren, vq[k].dwen,
            vq[k].daddr, vq[k].dstore, vq[k].rload, vq[k].rrdy);
      @(negedge CLK);
      check($sformatf("v%0d ramREN", k), 32'(ramREN), 32'(vq[k].e_ren));
      check($sformatf("v%0d ramWEN", k), 32'(ramWEN), 32'(vq[k].e_wen));
      check($sformatf("v%0d iwait", k), 32'(iwait), 32'(vq[k].e_iw));
      check($sformatf("v%0d dwait", k), 32'(dwait), 32'(vq[k].e_dw));
      check($sformatf("v%0d timeout_err", k), 32'(timeout_err), 32'(vq[k].e_err));
      if (vq[k].chk == 1) begin
        check($sformatf("v%0d ramaddr", k), ramaddr, vq[k].e_addr);
        check($sformatf("v%0d iload", k), iload, vq[k].e_load);
      end else if (vq[k].chk == 2) begin
        check($sformatf("v%0d ramaddr", k), ramaddr, vq[k].e_addr);
        check($sformatf("v%0d ramstore", k), ramstore, vq[k].e_store);
        check($sformatf("v%0d dload", k), dload, vq[k].e_load);
      end
      step();
    end

    // timeout: 16 stalled DACC cycles then ERR
    drive(0,0,32'h0,1,0,32'h300,32'h0,32'h0,0);
    @(negedge CLK);
    check("to grant dwait", 32'(dwait), 32'd1);
    check("to grant ramREN", 32'(ramREN), 32'd0);
    step();
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      check($sformatf("to dacc%0d ramREN", i), 32'(ramREN), 32'd1);
      check($sformatf("to dacc%0d timeout_err", i), 32'(timeout_err), 32'd0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      ramready = i[0];
      @(negedge CLK);
      check($sformatf("err%0d timeout_err", i), 32'(timeout_err), 32'd1);
      check($sformatf("err%0d dwait", i), 32'(dwait), 32'd1);
      check($sformatf("err%0d iwait", i), 32'(iwait), 32'd1);
      check($sformatf("err%0d ramREN", i), 32'(ramREN), 32'd0);
      check($sformatf("err%0d ramWEN", i), 32'(ramWEN), 32'd0);
      step();
    end
    drive(1,0,32'h0,1,0,32'h300,32'h0,32'h0,0);
    @(negedge CLK);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst dwait", 32'(dwait), 32'd1);
    step();
    drive(0,0,32'h0,0,0,32'h300,32'h0,32'h0,0);
    @(negedge CLK);
    check("post-rst timeout_err", 32'(timeout_err), 32'd0);
    check("post-rst ramREN", 32'(ramREN), 32'd0);
    step();
    drive(0,0,32'h0,1,0,32'h300,32'h0,32'h66666666,0);
    @(negedge CLK);
    check("post-rst grant ramREN", 32'(ramREN), 32'd0);
    step();
    ramready = 1'b1;
    @(negedge CLK);
    check("post-rst dacc ramREN", 32'(ramREN), 32'd1);
    check("post-rst dacc dwait", 32'(dwait), 32'd0);
    check("post-rst dacc dload", dload, 32'h66666666);
    step();
    drive(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
